// File: rtl/uart_pkg.sv
// Shared 8N1 serial framing definitions, used by the receiver and the transmitter.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam logic        START_BIT = 1'b0;
    localparam logic        STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitIdle
    } uart_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable reset value.
module sync2 #(
    parameter logic ResetVal = 1'b1
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the input through two flops; the synchronous reset forces both to ResetVal.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a one-entry holding register and ready/valid output handshake.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = 104
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam logic [15:0] BitCycles  = 16'(CLK_DIV);
    localparam logic [15:0] HalfCycles = 16'(CLK_DIV / 2);
    localparam logic [2:0]  LastBit    = 3'(DATA_BITS - 1);

    uart_state_e state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;

    logic rx_s;
    logic sample;

    sync2 #(
        .ResetVal(1'b1)
    ) u_sync2 (
        .clk_i   (clk),
        .reset_ni(reset_n),
        .d_i     (rx),
        .q_o     (rx_s)
    );

    // A sample is taken when the counter reaches 1; reloading with CLK_DIV then places the
    // next sample exactly CLK_DIV cycles later.
    assign sample = (cnt_q == 16'd1);

    // Next-state logic: bit timing, shifting, holding-register handshake and error pulses.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q & ~rx_ready;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;

        case (state_q)
            StIdle: begin
                if (rx_s == START_BIT) begin
                    state_d = StStart;
                    cnt_d   = HalfCycles;
                end
            end
            StStart: begin
                if (sample) begin
                    if (rx_s == START_BIT) begin
                        state_d   = StData;
                        bit_idx_d = 3'd0;
                        cnt_d     = BitCycles;
                    end else begin
                        // Start bit did not persist to mid-bit: treat as a glitch.
                        state_d = StIdle;
                        cnt_d   = 16'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StData: begin
                if (sample) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = BitCycles;
                    if (bit_idx_q == LastBit) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StStop: begin
                if (sample) begin
                    cnt_d     = 16'd0;
                    bit_idx_d = 3'd0;
                    if (rx_s == STOP_BIT) begin
                        state_d = StIdle;
                        // Load if empty, or if the current byte is being taken this edge.
                        if (!valid_q || rx_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        state_d = StWaitIdle;
                        ferr_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StWaitIdle: begin
                // Wait out a break so a held-low line reports only one framing error.
                if (rx_s == STOP_BIT) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 16'd0;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver with CLK_DIV=16 (one bit = 16 clocks).
module tb_uart_receiver;

    logic       clk;
    logic       reset_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;

    // Line driver state: frame bits (index 0 = start bit), position in clocks since the
    // start bit began, and an extra low stretch appended after the stop bit.
    logic [9:0] tx_bits  = 10'h3FF;
    int         pos      = 0;
    int         tail_low = 0;
    logic       drive_en = 1'b0;

    uart_receiver #(
        .CLK_DIV(16)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count single-cycle pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
    end

    function automatic logic line_level();
        if (pos < 160) return tx_bits[pos / 16];
        if (pos < 160 + tail_low) return 1'b0;
        return 1'b1;
    endfunction

    // Advance n clock edges; land 1 time unit after the last edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            pos++;
            if (drive_en) rx = line_level();
        end
    endtask

    task automatic start_frame(input logic [7:0] b, input logic stop_bit);
        tx_bits  = {stop_bit, b, 1'b0};
        pos      = 0;
        drive_en = 1'b1;
        rx       = tx_bits[0];
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Offsets below are clock edges after the start bit is driven (edge P). The two-flop
    // synchronizer puts detection at P+3 (D); stop sample at D+152 = P+155.
    initial begin
        rx       = 1'b1;
        reset_n  = 1'b0;
        rx_ready = 1'b0;
        step(2);
        check_byte("reset_rx_data", rx_data, 8'h00);
        check_bit("reset_rx_valid", rx_valid, 1'b0);
        check_bit("reset_frame_err", frame_err, 1'b0);
        check_bit("reset_overrun", overrun, 1'b0);
        check_bit("reset_busy", busy, 1'b0);
        reset_n = 1'b1;
        step(5);

        // 0x55 with consumer ready: valid for exactly one cycle
        rx_ready = 1'b1;
        start_frame(8'h55, 1'b1);
        step(2);
        check_bit("b55_idle_before_D", busy, 1'b0);
        step(1);
        check_bit("b55_busy_after_D", busy, 1'b1);
        step(151);
        check_bit("b55_valid_early", rx_valid, 1'b0);
        step(1);
        check_bit("b55_valid", rx_valid, 1'b1);
        check_byte("b55_data", rx_data, 8'h55);
        step(1);
        check_bit("b55_valid_one_cycle", rx_valid, 1'b0);
        check_int("b55_no_frame_err", fe_cnt, 0);
        check_int("b55_no_overrun", ov_cnt, 0);
        step(4);

        // Start-bit glitch: 5 low cycles
        drive_en = 1'b0;
        rx = 1'b0;
        pos = 0;
        step(3);
        check_bit("glitch_busy_D1", busy, 1'b1);
        step(2);
        rx = 1'b1;
        step(5);
        check_bit("glitch_busy_D8", busy, 1'b1);
        step(1);
        check_bit("glitch_idle_after_reject", busy, 1'b0);
        step(20);
        check_bit("glitch_no_valid", rx_valid, 1'b0);
        check_int("glitch_no_frame_err", fe_cnt, 0);

        // 0xA3 then 0x0F back-to-back, consumer stalled
        rx_ready = 1'b0;
        start_frame(8'hA3, 1'b1);
        step(155);
        check_bit("a3_valid", rx_valid, 1'b1);
        check_byte("a3_data", rx_data, 8'hA3);
        step(5);
        start_frame(8'h0F, 1'b1);
        step(154);
        check_bit("ovr_not_yet", overrun, 1'b0);
        step(1);
        check_bit("ovr_pulse", overrun, 1'b1);
        check_byte("ovr_data_held", rx_data, 8'hA3);
        check_bit("ovr_valid_held", rx_valid, 1'b1);
        step(1);
        check_bit("ovr_pulse_end", overrun, 1'b0);
        check_byte("ovr_data_still", rx_data, 8'hA3);
        step(4);

        // Accept on the same edge as the next stop sample: reload, no overrun
        start_frame(8'h5A, 1'b1);
        step(154);
        check_byte("same_edge_old_data", rx_data, 8'hA3);
        rx_ready = 1'b1;
        step(1);
        check_bit("same_edge_valid", rx_valid, 1'b1);
        check_byte("same_edge_data", rx_data, 8'h5A);
        check_bit("same_edge_no_ovr", overrun, 1'b0);
        step(1);
        check_bit("same_edge_drained", rx_valid, 1'b0);
        check_int("same_edge_ovr_total", ov_cnt, 1);
        step(4);

        // 0x81 with low stop bit and 40 more low cycles
        tail_low = 40;
        start_frame(8'h81, 1'b0);
        step(154);
        check_bit("ferr_not_yet", frame_err, 1'b0);
        step(1);
        check_bit("ferr_pulse", frame_err, 1'b1);
        step(1);
        check_bit("ferr_pulse_end", frame_err, 1'b0);
        step(40);
        check_bit("ferr_wait_idle_busy", busy, 1'b1);
        check_bit("ferr_no_valid", rx_valid, 1'b0);
        step(7);
        check_bit("ferr_back_idle", busy, 1'b0);
        check_int("ferr_single_pulse", fe_cnt, 1);
        tail_low = 0;
        step(5);
        start_frame(8'h7E, 1'b1);
        step(155);
        check_bit("b7e_valid", rx_valid, 1'b1);
        check_byte("b7e_data", rx_data, 8'h7E);
        step(5);

        // Reset for one cycle at D+60 of a frame (line is high there for 0xFC)
        start_frame(8'hFC, 1'b1);
        step(62);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        check_bit("midrst_busy", busy, 1'b0);
        check_bit("midrst_valid", rx_valid, 1'b0);
        check_byte("midrst_data", rx_data, 8'h00);
        check_bit("midrst_ferr", frame_err, 1'b0);
        check_bit("midrst_ovr", overrun, 1'b0);
        step(97);
        check_bit("midrst_no_valid", rx_valid, 1'b0);
        check_bit("midrst_idle", busy, 1'b0);
        start_frame(8'h3C, 1'b1);
        step(155);
        check_bit("b3c_valid", rx_valid, 1'b1);
        check_byte("b3c_data", rx_data, 8'h3C);
        check_int("final_frame_err_total", fe_cnt, 1);
        check_int("final_overrun_total", ov_cnt, 1);
        step(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 104, meaning clk cycles per bit (12 MHz / 115200); legal range 4..65535.
REQ-002 The block SHALL have port clk  input  1  sole clock, all state rising-edge.
REQ-003 The block SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port rx  input  1  serial line, asynchronous to clk, idle high.
REQ-005 The block SHALL have port rx_data  output  8  received byte, valid while rx_valid=1.
REQ-006 The block SHALL have port rx_valid  output  1  holding register full.
REQ-007 The block SHALL have port rx_ready  input  1  consumer accepts byte when rx_valid=1 and rx_ready=1 on the same edge.
REQ-008 The block SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 The block SHALL have port overrun  output  1  one-cycle pulse: completed byte dropped because holding register was full.
REQ-010 The block SHALL have port busy  output  1  high in every state other than IDLE.

Function
REQ-011 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-012 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-013 States SHALL be IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-014 IDLE: rx_s=0 (detection cycle D) -> START, with the bit counter loaded so the sample occurs CLK_DIV/2 (floor) cycles after D.
REQ-015 START sample: rx_s=0 -> DATA, bit index 0, counter reloaded to CLK_DIV; rx_s=1 -> IDLE (glitch rejected, no output).
REQ-016 DATA: each sample occurs CLK_DIV cycles after the previous one; sample i is shifted into bit i; after bit 7 -> STOP.
REQ-017 STOP sample occurs CLK_DIV cycles after the bit-7 sample, i.e. D + CLK_DIV/2 + 9*CLK_DIV.
REQ-018 STOP sample rx_s=1, holding register empty or accepted on the same edge -> rx_data loaded, rx_valid=1 from the next cycle, -> IDLE.
REQ-019 STOP sample rx_s=1, holding register full and not accepted -> byte dropped, rx_data unchanged, overrun pulsed for one cycle, -> IDLE.
REQ-020 STOP sample rx_s=0 -> byte discarded, frame_err pulsed for one cycle, -> WAIT_IDLE; WAIT_IDLE -> IDLE on the first cycle rx_s=1 (break held indefinitely yields one frame_err only).
REQ-021 rx_valid SHALL clear on the edge where rx_valid=1 and rx_ready=1, unless REQ-018 reloads on that edge, in which case it stays 1 with the new byte.
REQ-022 rx_data SHALL be stable while rx_valid=1 and not accepted.
REQ-023 Bit counter SHALL be 16 bits wide, count down, and reload without drift: exactly CLK_DIV cycles between consecutive samples.

Reset
REQ-024 On a clk edge with reset_n=0: state=IDLE, rx_valid=0, rx_data=8'h00, frame_err=0, overrun=0, busy=0, synchronizer flops=1, counter and bit index=0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no pulse; after release, reception restarts only on a fresh falling edge.

Structure
REQ-026 The state enum and 8N1 constants (DATA_BITS=8) SHALL live in shared package uart_pkg, reused by the future transmitter.
REQ-027 The synchronizer SHALL be sub-module sync2 (parameterized reset value); the rest is one always_ff plus next-state logic.

Verification (CLK_DIV=16, bit = 16 cycles)
REQ-028 Send 0x55, rx_ready=1 -> rx_valid high for exactly one cycle, at D+153, with rx_data=0x55; no error pulses.
REQ-029 Send 0xA3 then 0x0F back-to-back, rx_ready=0 -> first byte 0xA3 held, overrun pulse on the second stop sample, rx_data stays 0xA3.
REQ-030 rx low for 5 cycles then high -> START rejects at D+8, returns to IDLE, no rx_valid, busy high from D+1 to D+8.
REQ-031 Frame 0x81 with stop bit 0, rx held low 40 more cycles -> one frame_err pulse, no rx_valid, WAIT_IDLE until rx high, then 0x7E received correctly.
REQ-032 reset_n=0 for one cycle at D+60 of a frame -> all outputs at reset values, no rx_valid for that frame, next frame 0x3C received.
REQ-033 rx_valid=1 with rx_ready=1 on the same edge as the next byte's stop sample -> rx_valid stays 1, rx_data updates to the new byte, no overrun.
